div_arb: RTL and testbench

DIV_ARB -- requirements
Module: div_arb

---
 rtl/tinyriscv_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/div_arb.sv | 172 +++++++++++++++++
 tb/tb_div_arb.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyriscv_pkg.sv
// Shared core definitions: register widths, divider opcodes and divider-arbiter types.
package tinyriscv_pkg;

    localparam int unsigned RegBus     = 32;
    localparam int unsigned RegAddrBus = 5;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    localparam int unsigned DivArbTimeoutDefault = 48;

    typedef enum logic [1:0] {
        DIV_ARB_IDLE  = 2'd0,
        DIV_ARB_RUN   = 2'd1,
        DIV_ARB_DRAIN = 2'd2
    } div_arb_state_e;

    // Operation captured from the winning requester and presented to the divider.
    typedef struct packed {
        logic [2:0]            op;
        logic [RegBus-1:0]     dividend;
        logic [RegBus-1:0]     divisor;
        logic [RegAddrBus-1:0] waddr;
    } div_req_t;

    // Width of an index into n requesters; at least one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: the first active request at or after the pointer wins.
module rr_arbiter
    import tinyriscv_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [idx_width(NUM_REQ)-1:0]  ptr_i,
    output logic [NUM_REQ-1:0]             gnt_c
);

    localparam int unsigned PtrW = idx_width(NUM_REQ);

    logic [PtrW-1:0] idx;
    logic            found;

    // Scan requesters starting at the pointer, wrapping, and grant the first hit.
    always_comb begin
        gnt_c = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = PtrW'((32'(ptr_i) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                gnt_c[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_arb.sv
// Shares one iterative divider among NUM_REQ requesters with round-robin grant,
// kill, timeout and a one-cycle drain between operations.
module div_arb
    import tinyriscv_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = DivArbTimeoutDefault
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ-1:0][2:0]              req_op_i,
    input  logic [NUM_REQ-1:0][RegBus-1:0]       req_dividend_i,
    input  logic [NUM_REQ-1:0][RegBus-1:0]       req_divisor_i,
    input  logic [NUM_REQ-1:0][RegAddrBus-1:0]   req_waddr_i,
    input  logic [NUM_REQ-1:0]                   req_kill_i,
    output logic [NUM_REQ-1:0]                   rsp_valid_o,
    output logic                                 rsp_err_o,
    output logic [RegBus-1:0]                    rsp_result_o,
    output logic [RegAddrBus-1:0]                rsp_waddr_o,
    output logic                                 div_start_o,
    output logic [2:0]                           div_op_o,
    output logic [RegBus-1:0]                    div_dividend_o,
    output logic [RegBus-1:0]                    div_divisor_o,
    output logic [RegAddrBus-1:0]                div_waddr_o,
    input  logic                                 div_ready_i,
    input  logic [RegBus-1:0]                    div_result_i,
    input  logic                                 div_busy_i
);

    localparam int unsigned PtrW = idx_width(NUM_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);

    div_arb_state_e          state_q, state_d;
    logic [PtrW-1:0]         ptr_q, ptr_d;
    logic [PtrW-1:0]         owner_q, owner_d;
    div_req_t                lat_q, lat_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    start_q, start_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [RegBus-1:0]       rsp_result_q, rsp_result_d;
    logic [RegAddrBus-1:0]   rsp_waddr_q, rsp_waddr_d;

    logic [NUM_REQ-1:0]      gnt_c;
    logic [NUM_REQ-1:0]      ready_c;
    logic [PtrW-1:0]         grant_idx_c;
    logic                    unused_busy;

    // Busy is informational only; the ready handshake is authoritative.
    assign unused_busy = div_busy_i;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_c (gnt_c)
    );

    // Encode the one-hot grant into an owner index.
    always_comb begin
        grant_idx_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i]) begin
                grant_idx_c = PtrW'(i);
            end
        end
    end

    // Next-state, capture and response logic.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        lat_d        = lat_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = '0;
        rsp_err_d    = 1'b0;
        rsp_result_d = rsp_result_q;
        rsp_waddr_d  = rsp_waddr_q;
        ready_c      = '0;

        unique case (state_q)
            DIV_ARB_IDLE: begin
                ready_c = gnt_c;
                if (|gnt_c) begin
                    owner_d        = grant_idx_c;
                    lat_d.op       = req_op_i[grant_idx_c];
                    lat_d.dividend = req_dividend_i[grant_idx_c];
                    lat_d.divisor  = req_divisor_i[grant_idx_c];
                    lat_d.waddr    = req_waddr_i[grant_idx_c];
                    ptr_d          = (32'(grant_idx_c) == NUM_REQ - 1) ? '0
                                                                       : grant_idx_c + PtrW'(1);
                    cnt_d          = '0;
                    state_d        = DIV_ARB_RUN;
                end
            end
            DIV_ARB_RUN: begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                // Kill takes precedence over both completion and timeout.
                if (req_kill_i[owner_q]) begin
                    state_d = DIV_ARB_DRAIN;
                end else if (div_ready_i) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_result_d         = div_result_i;
                    rsp_waddr_d          = lat_q.waddr;
                    state_d              = DIV_ARB_DRAIN;
                end else if (cnt_q >= CntLast) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d            = 1'b1;
                    rsp_result_d         = '0;
                    rsp_waddr_d          = lat_q.waddr;
                    state_d              = DIV_ARB_DRAIN;
                end
            end
            DIV_ARB_DRAIN: begin
                state_d = DIV_ARB_IDLE;
            end
            default: begin
                state_d = DIV_ARB_IDLE;
            end
        endcase

        start_d = (state_d == DIV_ARB_RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= DIV_ARB_IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            lat_q        <= '0;
            cnt_q        <= '0;
            start_q      <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= '0;
            rsp_waddr_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            lat_q        <= lat_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_result_q <= rsp_result_d;
            rsp_waddr_q  <= rsp_waddr_d;
        end
    end

    // Ready is a same-cycle handshake, masked while reset is asserted.
    assign req_ready_o    = rst_i ? '0 : ready_c;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_err_o      = rsp_err_q;
    assign rsp_result_o   = rsp_result_q;
    assign rsp_waddr_o    = rsp_waddr_q;
    assign div_start_o    = start_q;
    assign div_op_o       = lat_q.op;
    assign div_dividend_o = lat_q.dividend;
    assign div_divisor_o  = lat_q.divisor;
    assign div_waddr_o    = lat_q.waddr;

endmodule

// File: tb/tb_div_arb.sv
// Directed bench for div_arb: the bench plays the divider and both requesters.
module tb_div_arb;
    import tinyriscv_pkg::*;

    logic                           clk_i = 1'b0;
    logic                           rst_i;
    logic [1:0]                     req_valid_i;
    logic [1:0]                     req_ready_o;
    logic [1:0][2:0]                req_op_i;
    logic [1:0][RegBus-1:0]         req_dividend_i;
    logic [1:0][RegBus-1:0]         req_divisor_i;
    logic [1:0][RegAddrBus-1:0]     req_waddr_i;
    logic [1:0]                     req_kill_i;
    logic [1:0]                     rsp_valid_o;
    logic                           rsp_err_o;
    logic [RegBus-1:0]              rsp_result_o;
    logic [RegAddrBus-1:0]          rsp_waddr_o;
    logic                           div_start_o;
    logic [2:0]                     div_op_o;
    logic [RegBus-1:0]              div_dividend_o;
    logic [RegBus-1:0]              div_divisor_o;
    logic [RegAddrBus-1:0]          div_waddr_o;
    logic                           div_ready_i;
    logic [RegBus-1:0]              div_result_i;
    logic                           div_busy_i;

    int tests_run = 0;
    int failed    = 0;

    div_arb #(.NUM_REQ(2), .TIMEOUT(48)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_dividend_i (req_dividend_i),
        .req_divisor_i  (req_divisor_i),
        .req_waddr_i    (req_waddr_i),
        .req_kill_i     (req_kill_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_err_o      (rsp_err_o),
        .rsp_result_o   (rsp_result_o),
        .rsp_waddr_o    (rsp_waddr_o),
        .div_start_o    (div_start_o),
        .div_op_o       (div_op_o),
        .div_dividend_o (div_dividend_o),
        .div_divisor_o  (div_divisor_o),
        .div_waddr_o    (div_waddr_o),
        .div_ready_i    (div_ready_i),
        .div_result_i   (div_result_i),
        .div_busy_i     (div_busy_i)
    );

    always #5 clk_i = ~clk_i;

    // RISC-V M-extension divider behaviour, used to drive div_result_i.
    function automatic logic [31:0] div_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            INST_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            INST_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            INST_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input logic who, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] wa);
        req_op_i[who]       = op;
        req_dividend_i[who] = a;
        req_divisor_i[who]  = b;
        req_waddr_i[who]    = wa;
        req_valid_i[who]    = 1'b1;
    endtask

    // Expect a grant to `who` in the current IDLE cycle, then RUN with start high.
    task automatic accept(input logic who, input string name);
        logic [1:0] exp;
        exp = who ? 2'b10 : 2'b01;
        #1;
        tests_run++;
        if (req_ready_o !== exp) begin
            failed++; $display("FAIL %s_ready: got %b want %b", name, req_ready_o, exp);
        end
        tick();
        req_valid_i[who] = 1'b0;
        tests_run++;
        if (div_start_o !== 1'b1) begin
            failed++; $display("FAIL %s_start: got %b want 1", name, div_start_o);
        end
    endtask

    // Divider answers in RUN cycle `lat`; expect owner-only pulse, DRAIN, then IDLE.
    task automatic complete(input logic who, input int lat, input logic [31:0] exp_res,
                            input logic [4:0] exp_wa, input string name);
        logic [1:0] exp;
        exp = who ? 2'b10 : 2'b01;
        for (int i = 1; i < lat; i++) tick();
        tests_run++;
        if (div_start_o !== 1'b1 || req_ready_o !== 2'b00 || rsp_valid_o !== 2'b00) begin
            failed++; $display("FAIL %s_run: start %b ready %b valid %b want 1 00 00",
                               name, div_start_o, req_ready_o, rsp_valid_o);
        end
        div_ready_i  = 1'b1;
        div_result_i = div_model(div_op_o, div_dividend_o, div_divisor_o);
        tick();
        div_ready_i  = 1'b0;
        div_result_i = '0;
        tests_run++;
        if (rsp_valid_o !== exp || rsp_err_o !== 1'b0) begin
            failed++; $display("FAIL %s_pulse: valid %b err %b want %b 0",
                               name, rsp_valid_o, rsp_err_o, exp);
        end
        tests_run++;
        if (rsp_result_o !== exp_res || rsp_waddr_o !== exp_wa) begin
            failed++; $display("FAIL %s_result: got %h/%0d want %h/%0d",
                               name, rsp_result_o, rsp_waddr_o, exp_res, exp_wa);
        end
        tests_run++;
        if (div_start_o !== 1'b0 || req_ready_o !== 2'b00) begin
            failed++; $display("FAIL %s_drain: start %b ready %b want 0 00",
                               name, div_start_o, req_ready_o);
        end
        tick();
        tests_run++;
        if (rsp_valid_o !== 2'b00 || rsp_result_o !== exp_res || div_waddr_o !== exp_wa) begin
            failed++; $display("FAIL %s_hold: valid %b result %h dwaddr %0d want 00 %h %0d",
                               name, rsp_valid_o, rsp_result_o, div_waddr_o, exp_res, exp_wa);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        req_valid_i = '0; req_kill_i = '0; req_op_i = '0;
        req_dividend_i = '0; req_divisor_i = '0; req_waddr_i = '0;
        div_ready_i = 1'b0; div_result_i = '0; div_busy_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        tests_run++;
        if (req_ready_o !== 2'b00 || rsp_valid_o !== 2'b00 || rsp_err_o !== 1'b0 ||
            div_start_o !== 1'b0) begin
            failed++; $display("FAIL reset_ctrl: ready %b valid %b err %b start %b want all 0",
                               req_ready_o, rsp_valid_o, rsp_err_o, div_start_o);
        end
        tests_run++;
        if (rsp_result_o !== '0 || rsp_waddr_o !== '0 || div_op_o !== '0 ||
            div_dividend_o !== '0 || div_divisor_o !== '0 || div_waddr_o !== '0) begin
            failed++; $display("FAIL reset_data: result %h waddr %0d op %0d dvd %h dvs %h want 0",
                               rsp_result_o, rsp_waddr_o, div_op_o, div_dividend_o, div_divisor_o);
        end
    endtask

    task automatic test_divu();
        set_req(1'b0, INST_DIVU, 32'd100, 32'd7, 5'd5);
        accept(1'b0, "divu");
        tests_run++;
        if (div_op_o !== INST_DIVU || div_dividend_o !== 32'd100 || div_divisor_o !== 32'd7 ||
            div_waddr_o !== 5'd5) begin
            failed++; $display("FAIL divu_operands: got %0d %0d %0d %0d want 5 100 7 5",
                               div_op_o, div_dividend_o, div_divisor_o, div_waddr_o);
        end
        complete(1'b0, 6, 32'd14, 5'd5, "divu");
    endtask

    task automatic test_round_robin();
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        // Pair A from reset: req0 has priority, req1 follows back-to-back.
        set_req(1'b0, INST_DIVU, 32'd100, 32'd10, 5'd1);
        set_req(1'b1, INST_DIVU, 32'd64, 32'd8, 5'd2);
        accept(1'b0, "rr_a0");
        complete(1'b0, 2, 32'd10, 5'd1, "rr_a0");
        accept(1'b1, "rr_a1");
        complete(1'b1, 2, 32'd8, 5'd2, "rr_a1");
        // A lone req0 grant leaves priority with req1.
        set_req(1'b0, INST_DIVU, 32'd30, 32'd3, 5'd3);
        accept(1'b0, "rr_lone");
        complete(1'b0, 1, 32'd10, 5'd3, "rr_lone");
        // Pair B: req1 now goes first.
        set_req(1'b0, INST_DIVU, 32'd77, 32'd7, 5'd4);
        set_req(1'b1, INST_DIVU, 32'd81, 32'd9, 5'd6);
        accept(1'b1, "rr_b1");
        complete(1'b1, 2, 32'd9, 5'd6, "rr_b1");
        accept(1'b0, "rr_b0");
        complete(1'b0, 2, 32'd11, 5'd4, "rr_b0");
    endtask

    task automatic test_div_special();
        set_req(1'b1, INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd11);
        accept(1'b1, "rem_neg");
        complete(1'b1, 3, 32'hFFFF_FFFF, 5'd11, "rem_neg");
        set_req(1'b0, INST_DIV, 32'd123, 32'd0, 5'd12);
        accept(1'b0, "div_zero");
        complete(1'b0, 4, 32'hFFFF_FFFF, 5'd12, "div_zero");
    endtask

    task automatic test_kill();
        set_req(1'b0, INST_DIVU, 32'd50, 32'd5, 5'd3);
        accept(1'b0, "kill");
        req_kill_i[1] = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        req_kill_i[1] = 1'b0;
        tests_run++;
        if (div_start_o !== 1'b1 || rsp_valid_o !== 2'b00) begin
            failed++; $display("FAIL kill_nonowner: start %b valid %b want 1 00",
                               div_start_o, rsp_valid_o);
        end
        req_kill_i[0] = 1'b1;
        set_req(1'b1, INST_DIVU, 32'd40, 32'd8, 5'd13);
        tick();
        req_kill_i[0] = 1'b0;
        tests_run++;
        if (div_start_o !== 1'b0 || rsp_valid_o !== 2'b00 || req_ready_o !== 2'b00) begin
            failed++; $display("FAIL kill_drain: start %b valid %b ready %b want 0 00 00",
                               div_start_o, rsp_valid_o, req_ready_o);
        end
        tick();
        accept(1'b1, "kill_next");
        tick(); tick();
        // Kill and divider ready in the same cycle: kill wins.
        req_kill_i[1] = 1'b1;
        div_ready_i   = 1'b1;
        div_result_i  = 32'd5;
        tick();
        req_kill_i[1] = 1'b0;
        div_ready_i   = 1'b0;
        div_result_i  = '0;
        tests_run++;
        if (div_start_o !== 1'b0 || rsp_valid_o !== 2'b00) begin
            failed++; $display("FAIL kill_coincident: start %b valid %b want 0 00",
                               div_start_o, rsp_valid_o);
        end
        tick();
        tests_run++;
        if (rsp_valid_o !== 2'b00 || rsp_result_o !== 32'hFFFF_FFFF) begin
            failed++; $display("FAIL kill_noresp: valid %b result %h want 00 ffffffff",
                               rsp_valid_o, rsp_result_o);
        end
    endtask

    task automatic test_timeout();
        int n;
        set_req(1'b1, INST_DIVU, 32'd9, 32'd3, 5'd7);
        accept(1'b1, "timeout");
        n = 0;
        while (div_start_o === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        tests_run++;
        if (n != 48) begin
            failed++; $display("FAIL timeout_cycles: got %0d want 48", n);
        end
        tests_run++;
        if (rsp_valid_o !== 2'b10 || rsp_err_o !== 1'b1 || rsp_result_o !== '0 ||
            rsp_waddr_o !== 5'd7) begin
            failed++; $display("FAIL timeout_pulse: valid %b err %b result %h waddr %0d want 10 1 0 7",
                               rsp_valid_o, rsp_err_o, rsp_result_o, rsp_waddr_o);
        end
        set_req(1'b0, INST_DIVU, 32'd21, 32'd3, 5'd8);
        #1;
        tests_run++;
        if (req_ready_o !== 2'b00 || div_start_o !== 1'b0) begin
            failed++; $display("FAIL timeout_drain: ready %b start %b want 00 0",
                               req_ready_o, div_start_o);
        end
        tick();
        tests_run++;
        if (rsp_valid_o !== 2'b00 || rsp_err_o !== 1'b0) begin
            failed++; $display("FAIL timeout_idle: valid %b err %b want 00 0", rsp_valid_o, rsp_err_o);
        end
        accept(1'b0, "post_timeout");
        complete(1'b0, 2, 32'd7, 5'd8, "post_timeout");
    endtask

    task automatic test_reset_mid_run();
        set_req(1'b0, INST_DIVU, 32'd20, 32'd4, 5'd9);
        accept(1'b0, "rst_run");
        tick(); tick(); tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tests_run++;
        if (div_start_o !== 1'b0 || rsp_valid_o !== 2'b00 || rsp_err_o !== 1'b0 ||
            rsp_result_o !== '0 || rsp_waddr_o !== '0 || div_dividend_o !== '0 ||
            req_ready_o !== 2'b00) begin
            failed++; $display("FAIL rst_run_outputs: start %b valid %b result %h dvd %h want all 0",
                               div_start_o, rsp_valid_o, rsp_result_o, div_dividend_o);
        end
        tick();
        tests_run++;
        if (rsp_valid_o !== 2'b00 || div_start_o !== 1'b0) begin
            failed++; $display("FAIL rst_run_quiet: valid %b start %b want 00 0", rsp_valid_o, div_start_o);
        end
        // Priority was with req1 before reset; reset returns it to req0.
        set_req(1'b0, INST_DIVU, 32'd20, 32'd4, 5'd9);
        set_req(1'b1, INST_REMU, 32'd20, 32'd6, 5'd10);
        accept(1'b0, "rst_regrant0");
        complete(1'b0, 2, 32'd5, 5'd9, "rst_regrant0");
        accept(1'b1, "rst_regrant1");
        complete(1'b1, 2, 32'd2, 5'd10, "rst_regrant1");
    endtask

    initial begin
        test_reset();
        test_divu();
        test_round_robin();
        test_div_special();
        test_kill();
        test_timeout();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
        $fatal(1);
    end

endmodule
